// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: byte-serial RAM/IO port shared between instruction fetch and load/store buffer (optional MC_IO_STALL_EN holds IO stores while the UART buffer is full)
module mem_ctrl_arbiter #(
  parameter int ADDR_W = 32,
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_to_mc_ready,
  input  logic [ADDR_W-1:0] if_to_mc_PC,
  output logic              mc_valid,
  output logic              mc_to_if_ready,
  output logic [31:0]       mc_to_if_inst,
  input  logic              lsb_to_mc_ready,
  input  logic              lsb_to_mc_wr,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [1:0]        lsb_to_mc_size,
  input  logic [31:0]       lsb_to_mc_data,
  output logic              mc_to_lsb_ready,
  output logic [31:0]       mc_to_lsb_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic owner_lsb, wr_q;
  logic [2:0] len, cnt;
  logic [31:0] buf_q, wdata, merged;
  logic [ADDR_W-1:0] a_nxt;
  logic busy_pulse;
  // A store byte to the IO region must wait while the UART buffer cannot take it
  function automatic logic io_hold(input logic [ADDR_W-1:0] a);
`ifdef MC_IO_STALL_EN
    return io_buffer_full && a[17:16] == IO_HI;
`else
    return 1'b0 && io_buffer_full && a[17:16] == IO_HI;
`endif
  endfunction
  assign a_nxt = mem_a + 1'b1;
  assign merged = buf_q | ({24'b0, mem_din} << {cnt, 3'b0});
  assign busy_pulse = mc_to_if_ready | mc_to_lsb_ready;
  assign mem_wr = wr_q & rdy_in;
  // Arbitration, byte sequencing and result registration
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      owner_lsb <= 1'b0;
      len <= '0;
      cnt <= '0;
      buf_q <= '0;
      wdata <= '0;
      wr_q <= 1'b0;
      mem_a <= '0;
      mem_dout <= '0;
      mc_valid <= 1'b0;
      mc_to_if_ready <= 1'b0;
      mc_to_if_inst <= '0;
      mc_to_lsb_ready <= 1'b0;
      mc_to_lsb_data <= '0;
    end else if (rdy_in) begin
      mc_valid <= 1'b0;
      mc_to_if_ready <= 1'b0;
      mc_to_lsb_ready <= 1'b0;
      case (state)
        IDLE: if (!clr_in && !busy_pulse) begin
          if (lsb_to_mc_ready) begin
            owner_lsb <= 1'b1;
            len <= lsb_to_mc_size == 2'b00 ? 3'd1 : lsb_to_mc_size == 2'b01 ? 3'd2 : 3'd4;
            cnt <= '0;
            buf_q <= '0;
            mem_a <= lsb_to_mc_addr;
            wdata <= lsb_to_mc_data;
            mem_dout <= lsb_to_mc_data[7:0];
            state <= lsb_to_mc_wr ? WRITE : READ;
            wr_q <= lsb_to_mc_wr && !io_hold(lsb_to_mc_addr);
          end else if (if_to_mc_ready) begin
            mc_valid <= 1'b1;
            owner_lsb <= 1'b0;
            len <= 3'd4;
            cnt <= '0;
            buf_q <= '0;
            mem_a <= if_to_mc_PC;
            wr_q <= 1'b0;
            state <= READ;
          end
        end
        READ: if (clr_in) begin
          state <= IDLE;
          wr_q <= 1'b0;
        end else if (cnt == len - 3'd1) begin
          state <= IDLE;
          if (owner_lsb) begin
            mc_to_lsb_ready <= 1'b1;
            mc_to_lsb_data <= merged;
          end else begin
            mc_to_if_ready <= 1'b1;
            mc_to_if_inst <= merged;
          end
        end else begin
          buf_q <= merged;
          cnt <= cnt + 3'd1;
          mem_a <= a_nxt;
        end
        WRITE: if (!wr_q) begin
          wr_q <= !io_hold(mem_a);
        end else if (cnt == len - 3'd1) begin
          wr_q <= 1'b0;
          mc_to_lsb_ready <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt + 3'd1;
          mem_a <= a_nxt;
          wdata <= wdata >> 8;
          mem_dout <= wdata[15:8];
          wr_q <= !io_hold(a_nxt);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb_mem_ctrl_arbiter: directed checks of fetch, load, store, flush, stall and reset behaviour
module tb_mem_ctrl_arbiter;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clr_in = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_a, if_to_mc_PC = '0, lsb_to_mc_addr = '0, lsb_to_mc_data = '0;
  logic [31:0] mc_to_if_inst, mc_to_lsb_data, w;
  logic mem_wr, if_to_mc_ready = 1'b0, mc_valid, mc_to_if_ready;
  logic lsb_to_mc_ready = 1'b0, lsb_to_mc_wr = 1'b0, mc_to_lsb_ready;
  logic [1:0] lsb_to_mc_size = '0;
  logic [7:0] ram [0:1023];
  int n_cmp = 0, n_bad = 0;

  mem_ctrl_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .if_to_mc_ready(if_to_mc_ready),
    .if_to_mc_PC(if_to_mc_PC), .mc_valid(mc_valid), .mc_to_if_ready(mc_to_if_ready),
    .mc_to_if_inst(mc_to_if_inst), .lsb_to_mc_ready(lsb_to_mc_ready),
    .lsb_to_mc_wr(lsb_to_mc_wr), .lsb_to_mc_addr(lsb_to_mc_addr),
    .lsb_to_mc_size(lsb_to_mc_size), .lsb_to_mc_data(lsb_to_mc_data),
    .mc_to_lsb_ready(mc_to_lsb_ready), .mc_to_lsb_data(mc_to_lsb_data)
  );

  always #5 clk_in = ~clk_in;
  assign mem_din = ram[mem_a[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    lsb_to_mc_ready = 1'b1;
    lsb_to_mc_wr = wr;
    lsb_to_mc_addr = a;
    lsb_to_mc_size = sz;
    lsb_to_mc_data = d;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h10] = 8'h13; ram[10'h11] = 8'h05; ram[10'h12] = 8'h10; ram[10'h13] = 8'h00;
    ram[10'h20] = 8'h01; ram[10'h21] = 8'h02; ram[10'h22] = 8'h03; ram[10'h23] = 8'h04;
    ram[10'h80] = 8'haa; ram[10'h81] = 8'hbb; ram[10'h82] = 8'hcc; ram[10'h83] = 8'hdd;
    ram[10'h100] = 8'h34; ram[10'h101] = 8'h12; ram[10'h102] = 8'h99;
    tick; tick;
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_valid", mc_valid, 0);
    chk("rst_if_rdy", mc_to_if_ready, 0);
    chk("rst_inst", mc_to_if_inst, 0);
    chk("rst_lsb_rdy", mc_to_lsb_ready, 0);
    chk("rst_lsb_data", mc_to_lsb_data, 0);
    chk("rst_dout", mem_dout, 0);
    rst_in = 1'b1;
    // plain word fetch
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h10;
    tick;
    chk("f1_valid", mc_valid, 1);
    chk("f1_a0", mem_a, 32'h10);
    if_to_mc_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("f1_a", mem_a, 32'h10 + i);
      chk("f1_nordy", mc_to_if_ready, 0);
    end
    chk("f1_valid_pulse", mc_valid, 0);
    tick;
    chk("f1_rdy", mc_to_if_ready, 1);
    chk("f1_inst", mc_to_if_inst, 32'h00100513);
    tick;
    chk("f1_rdy_pulse", mc_to_if_ready, 0);
    // simultaneous IF and LSB half load: LSB wins
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h20;
    lsb_req(1'b0, 32'h100, 2'b01, 0);
    tick;
    chk("arb_no_valid", mc_valid, 0);
    chk("arb_a0", mem_a, 32'h100);
    tick;
    chk("arb_a1", mem_a, 32'h101);
    tick;
    chk("ld_rdy", mc_to_lsb_ready, 1);
    chk("ld_data", mc_to_lsb_data, 32'h00001234);
    lsb_to_mc_ready = 1'b0;
    tick;
    chk("arb_hold_off", mc_valid, 0);
    tick;
    chk("arb_if_valid", mc_valid, 1);
    chk("arb_if_a", mem_a, 32'h20);
    if_to_mc_ready = 1'b0;
    repeat (4) tick;
    chk("arb_if_rdy", mc_to_if_ready, 1);
    chk("arb_if_inst", mc_to_if_inst, 32'h04030201);
    tick;
    // byte load zero fill, then size 11 treated as word
    lsb_req(1'b0, 32'h101, 2'b00, 0);
    tick; tick;
    chk("ldb_rdy", mc_to_lsb_ready, 1);
    chk("ldb_data", mc_to_lsb_data, 32'h00000012);
    lsb_req(1'b0, 32'h10, 2'b11, 0);
    tick;
    lsb_to_mc_ready = 1'b1;
    repeat (4) tick;
    chk("ldw_nrdy", mc_to_lsb_ready, 0);
    tick;
    chk("ldw_rdy", mc_to_lsb_ready, 1);
    chk("ldw_data", mc_to_lsb_data, 32'h00100513);
    lsb_to_mc_ready = 1'b0;
    tick;
    // word store
    w = 32'hDEADBEEF;
    lsb_req(1'b1, 32'h200, 2'b10, w);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("st_wr", mem_wr, 1);
      chk("st_a", mem_a, 32'h200 + i);
      chk("st_d", mem_dout, (w >> (8 * i)) & 32'hff);
      chk("st_nrdy", mc_to_lsb_ready, 0);
    end
    tick;
    chk("st_wr_end", mem_wr, 0);
    chk("st_rdy", mc_to_lsb_ready, 1);
    lsb_to_mc_ready = 1'b0;
    tick;
    chk("st_rdy_pulse", mc_to_lsb_ready, 0);
    chk("st_wr_after", mem_wr, 0);
    // fetch aborted by clr two cycles after accept
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h10;
    tick;
    chk("clr_valid", mc_valid, 1);
    if_to_mc_ready = 1'b0;
    tick;
    clr_in = 1'b1;
    tick;
    chk("clr_wr", mem_wr, 0);
    clr_in = 1'b0;
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h80;
    tick;
    chk("clr_new_valid", mc_valid, 1);
    chk("clr_new_a", mem_a, 32'h80);
    if_to_mc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("clr_no_rdy", mc_to_if_ready, 0);
    end
    tick;
    chk("clr_new_rdy", mc_to_if_ready, 1);
    chk("clr_new_inst", mc_to_if_inst, 32'hddccbbaa);
    tick;
    // clr during a store is ignored
    w = 32'h11223344;
    lsb_req(1'b1, 32'h204, 2'b10, w);
    for (int i = 0; i < 4; i++) begin
      tick;
      clr_in = (i == 0);
      chk("cst_wr", mem_wr, 1);
      chk("cst_d", mem_dout, (w >> (8 * i)) & 32'hff);
    end
    clr_in = 1'b0;
    tick;
    chk("cst_rdy", mc_to_lsb_ready, 1);
    lsb_to_mc_ready = 1'b0;
    tick;
    // rdy_in low for three cycles mid-read
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h10;
    tick;
    if_to_mc_ready = 1'b0;
    tick;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_a", mem_a, 32'h11);
      chk("stall_wr", mem_wr, 0);
      chk("stall_rdy", mc_to_if_ready, 0);
    end
    rdy_in = 1'b1;
    tick;
    chk("stall_a2", mem_a, 32'h12);
    tick;
    chk("stall_a3", mem_a, 32'h13);
    tick;
    chk("stall_rdy_end", mc_to_if_ready, 1);
    chk("stall_inst", mc_to_if_inst, 32'h00100513);
    tick;
    // rdy_in gates mem_wr combinationally during a store
    lsb_req(1'b1, 32'h210, 2'b00, 32'h7f);
    tick;
    chk("gate_wr_on", mem_wr, 1);
    rdy_in = 1'b0;
    #1;
    chk("gate_wr_off", mem_wr, 0);
    tick;
    rdy_in = 1'b1;
    #1;
    chk("gate_wr_back", mem_wr, 1);
    tick;
    chk("gate_rdy", mc_to_lsb_ready, 1);
    lsb_to_mc_ready = 1'b0;
    tick;
    // byte store to the IO region while the UART buffer is full
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h30000, 2'b00, 32'h5a);
`ifdef MC_IO_STALL_EN
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("io_hold_wr", mem_wr, 0);
      chk("io_hold_rdy", mc_to_lsb_ready, 0);
    end
    io_buffer_full = 1'b0;
    tick;
    chk("io_wr", mem_wr, 1);
    chk("io_a", mem_a, 32'h30000);
    chk("io_d", mem_dout, 32'h5a);
    tick;
    chk("io_rdy", mc_to_lsb_ready, 1);
`else
    tick;
    chk("io_wr", mem_wr, 1);
    chk("io_a", mem_a, 32'h30000);
    chk("io_d", mem_dout, 32'h5a);
    tick;
    chk("io_rdy", mc_to_lsb_ready, 1);
    chk("io_wr_end", mem_wr, 0);
`endif
    lsb_to_mc_ready = 1'b0;
    io_buffer_full = 1'b0;
    tick;
    // reset in the middle of a fetch
    if_to_mc_ready = 1'b1; if_to_mc_PC = 32'h20;
    tick;
    if_to_mc_ready = 1'b0;
    tick;
    rst_in = 1'b0;
    tick;
    chk("mrst_a", mem_a, 32'h0);
    chk("mrst_inst", mc_to_if_inst, 32'h0);
    chk("mrst_lsb_data", mc_to_lsb_data, 32'h0);
    rst_in = 1'b1;
    repeat (5) tick;
    chk("mrst_no_rdy", mc_to_if_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
